mips_bus_arbiter: RTL
=====================

Name: mips_bus_arbiter

Overview:
Two-master to one-slave Avalon-MM arbiter, placed between the CPU's data port (m0) and instruction-fetch port (m1) and the shared memory bus.
- Grants the bus to one master at a time and holds the grant until that transaction completes.
- For reads, the grant is held until the read data has been returned.
- Forwards address, writedata and byteenable to the slave, and steers readdata back to the granted master.
- Decouples the CPU's fetch and data paths so a later pipelined core can issue both without external muxing.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- READ_LATENCY, 1, cycles from slave read acceptance to valid s_readdata. Legal range is 1..7.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- m0_address  in  ADDR_W  data master address.
- m0_read  in  1  data master read request.
- m0_write  in  1  data master write request.
- m0_writedata  in  DATA_W  data master write data.
- m0_byteenable  in  DATA_W/8  data master byte lanes.
- m0_waitrequest  out  1  stall to data master.
- m0_readdata  out  DATA_W  read data to data master.
- m0_readdatavalid  out  1  m0_readdata valid strobe.
- m1_address, m1_read, m1_write, m1_writedata, m1_byteenable, m1_waitrequest, m1_readdata, m1_readdatavalid: identical to m0, for the fetch master.
- s_address  out  ADDR_W  slave address.
- s_read  out  1  slave read.
- s_write  out  1  slave write.
- s_writedata  out  DATA_W  slave write data.
- s_byteenable  out  DATA_W/8  slave byte lanes.
- s_waitrequest  in  1  slave stall.
- s_readdata  in  DATA_W  slave read data.

Behaviour:
- Request definition: master X requests when mX_read or mX_write is high. Masters hold all request signals stable until they see mX_waitrequest low (Avalon rule).
- Read and write together: if a master asserts both, the write is performed and the read is ignored.
- States: IDLE, OWN0, OWN1, RDWAIT.
- Registers:
  - owner: which master holds the bus.
  - last: master most recently granted, for round-robin.
  - lat_cnt: 3-bit read-latency counter.

State transitions:
- IDLE:
  - s_read = s_write = 0; both mX_waitrequest = 1.
  - At the clock edge, a requester moves the FSM to OWNx. Grant is registered, so arbitration costs one cycle.
  - Only one master requesting: that master is granted.
  - Both requesting: the master other than `last` is granted; `last` is then updated to the granted master.
- OWNx:
  - s_* outputs = mX_* inputs (combinational); mX_waitrequest = s_waitrequest; the other master's waitrequest = 1.
  - While s_waitrequest = 1, the FSM stays in OWNx, with no time limit.
  - Write accepted (s_waitrequest = 0): next state is IDLE.
  - Read accepted: next state is RDWAIT with lat_cnt = READ_LATENCY-1.
- RDWAIT:
  - s_read = s_write = 0; both mX_waitrequest = 1.
  - When lat_cnt = 0: mX_readdatavalid = 1 and mX_readdata = s_readdata for the owner only; next state is IDLE.
  - Otherwise lat_cnt decrements.
- Readdata steering: mX_readdata mirrors s_readdata at all times; only mX_readdatavalid qualifies it. The non-owner's readdatavalid is always 0.
- Back-to-back transactions: minimum of 2 cycles per write and 2+READ_LATENCY cycles per read, including the IDLE arbitration cycle.
- Fairness: with both masters continuously requesting, grants alternate 0, 1, 0, 1, ...

Reset:
- Reset value: state = IDLE, last = 1 (so m0 wins the first tie), lat_cnt = 0.
- Outputs during reset: all s_* = 0; mX_waitrequest = 1; mX_readdatavalid = 0.
- Reset mid-operation: asserting reset in any state immediately forces the reset outputs. Any in-flight transaction is abandoned with no readdatavalid. Release resumes from IDLE.

Optional Feature:
- Macro: BUS_ARB_FIXED_PRIO_EN.
- Defined: m0 always wins a tie and `last` is unused, so fetch can be starved by a continuous data stream.
- Undefined (default): round-robin as above.
- The macro has no effect on single-requester behaviour.

Test Plan:
- Reset low, m0_read = 1 -> s_read = 0, m0_waitrequest = 1. Release reset -> s_read = 1 with s_address = m0_address one cycle later.
- m1 read of 0xBFC00000, s_waitrequest low on the first OWN cycle, slave returns 0x24020005 one cycle later (READ_LATENCY=1) -> m1_readdatavalid pulses for exactly 1 cycle with m1_readdata = 0x24020005; m0_readdatavalid stays 0.
- m0 write of 0x000000AB to 0x00001000 with byteenable = 0001 and s_waitrequest held high for 3 cycles -> s_write is high for 4 cycles with stable s_writedata/s_byteenable; m1_waitrequest stays 1 throughout.
- m0 and m1 both requesting reads continuously for 4 transactions -> grant order 0, 1, 0, 1. With BUS_ARB_FIXED_PRIO_EN defined -> order 0, 0, 0, 0.
- m0 asserts read and write together -> only s_write is asserted; no readdatavalid is produced.
- Reset asserted during RDWAIT (READ_LATENCY=3, lat_cnt = 1) -> no readdatavalid is produced; after release the next request is granted from IDLE with m0 winning the tie.

Source files
------------

// File: rtl/mips_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mips_bus_arbiter
//
// Two-master to one-slave Avalon-MM arbiter. m0 is the CPU data port, m1 the
// instruction-fetch port; both share a single memory slave.
//
// One master owns the bus at a time. Arbitration happens in IDLE and is
// registered, so every transaction pays one arbitration cycle. A write releases
// the bus as soon as the slave accepts it; a read holds the bus until the read
// data has come back READ_LATENCY cycles after acceptance.
//
// Parameters:
//   ADDR_W        address width of all ports
//   DATA_W        data width; byteenable is DATA_W/8 bits
//   READ_LATENCY  cycles from slave read acceptance to valid s_readdata (1..7)
//
// Ports:
//   clk, reset                     clock, asynchronous active-low reset
//   m0_* (data master)             address/read/write/writedata/byteenable in,
//                                  waitrequest/readdata/readdatavalid out
//   m1_* (fetch master)            same as m0_*
//   s_*  (slave)                   address/read/write/writedata/byteenable out,
//                                  waitrequest/readdata in
//
// Configuration macro:
//   BUS_ARB_FIXED_PRIO_EN  when defined, m0 always wins a tie (fetch may starve
//                          under a continuous data stream). When undefined the
//                          tie goes to the master not granted most recently.
// -----------------------------------------------------------------------------
module mips_bus_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset,

    // Data master
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,

    // Fetch master
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,

    // Slave
    output logic [ADDR_W-1:0]   s_address,
    output logic                s_read,
    output logic                s_write,
    output logic [DATA_W-1:0]   s_writedata,
    output logic [DATA_W/8-1:0] s_byteenable,
    input  logic                s_waitrequest,
    input  logic [DATA_W-1:0]   s_readdata
);

    localparam int unsigned BE_W = DATA_W / 8;

    // Counter load value on read acceptance; the data cycle is the one where
    // the counter has reached zero.
    localparam logic [2:0] LAT_INIT = 3'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        StIdle,
        StOwn0,
        StOwn1,
        StRdWait
    } state_e;

    state_e     state_q, state_d;
    logic       owner_q, owner_d;    // 0: m0 owns the bus, 1: m1 owns it
    logic       last_q, last_d;      // master granted most recently
    logic [2:0] lat_cnt_q, lat_cnt_d;

    logic m0_req, m1_req;
    logic tie_winner;
    logic grant;

    // Owner-selected request signals, used while in an OWN state.
    logic [ADDR_W-1:0] sel_address;
    logic              sel_read;
    logic              sel_write;
    logic [DATA_W-1:0] sel_writedata;
    logic [BE_W-1:0]   sel_byteenable;

    assign m0_req = m0_read | m0_write;
    assign m1_req = m1_read | m1_write;

`ifdef BUS_ARB_FIXED_PRIO_EN
    assign tie_winner = 1'b0;
`else
    assign tie_winner = ~last_q;
`endif

    always_comb begin
        if (owner_q) begin
            sel_address    = m1_address;
            sel_read       = m1_read;
            sel_write      = m1_write;
            sel_writedata  = m1_writedata;
            sel_byteenable = m1_byteenable;
        end else begin
            sel_address    = m0_address;
            sel_read       = m0_read;
            sel_write      = m0_write;
            sel_writedata  = m0_writedata;
            sel_byteenable = m0_byteenable;
        end
    end

    // Read data is broadcast; only readdatavalid tells a master it is theirs.
    assign m0_readdata = s_readdata;
    assign m1_readdata = s_readdata;

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d          = state_q;
        owner_d          = owner_q;
        last_d           = last_q;
        lat_cnt_d        = lat_cnt_q;
        grant            = 1'b0;

        s_address        = '0;
        s_read           = 1'b0;
        s_write          = 1'b0;
        s_writedata      = '0;
        s_byteenable     = '0;
        m0_waitrequest   = 1'b1;
        m1_waitrequest   = 1'b1;
        m0_readdatavalid = 1'b0;
        m1_readdatavalid = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (m0_req || m1_req) begin
                    if (m0_req && m1_req) begin
                        grant = tie_winner;
                    end else begin
                        grant = m1_req;
                    end
                    owner_d = grant;
                    last_d  = grant;
                    state_d = grant ? StOwn1 : StOwn0;
                end
            end

            StOwn0, StOwn1: begin
                s_address    = sel_address;
                // A simultaneous read and write is treated as a write only.
                s_write      = sel_write;
                s_read       = sel_read & ~sel_write;
                s_writedata  = sel_writedata;
                s_byteenable = sel_byteenable;

                if (owner_q) begin
                    m1_waitrequest = s_waitrequest;
                end else begin
                    m0_waitrequest = s_waitrequest;
                end

                if (!s_waitrequest) begin
                    if (sel_write) begin
                        state_d = StIdle;
                    end else if (sel_read) begin
                        state_d   = StRdWait;
                        lat_cnt_d = LAT_INIT;
                    end else begin
                        // Request withdrawn against protocol; release the bus.
                        state_d = StIdle;
                    end
                end
            end

            StRdWait: begin
                if (lat_cnt_q == 3'd0) begin
                    if (owner_q) begin
                        m1_readdatavalid = 1'b1;
                    end else begin
                        m0_readdatavalid = 1'b1;
                    end
                    state_d = StIdle;
                end else begin
                    lat_cnt_d = lat_cnt_q - 3'd1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // last resets to m1 so that m0 wins the first tie after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            lat_cnt_q <= 3'd0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            lat_cnt_q <= lat_cnt_d;
        end
    end

endmodule
